sysid_read_master: RTL and testbench
====================================

SYSID_READ_MASTER -- requirements
Module: sysid_read_master

Interface
REQ-001 SHALL have parameter EXPECTED_ID, default 32'd0, meaning the system ID word expected at word address 0.
REQ-002 SHALL have parameter EXPECTED_TIMESTAMP, default 32'd1392009444, meaning the timestamp word expected at word address 1.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16'd1023, meaning the maximum number of cycles one read may stall on waitrequest.
REQ-004 clock  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse requesting a check sequence.
REQ-007 busy  output  1  high while a sequence is in progress.
REQ-008 done  output  1  one-cycle pulse when a sequence ends, by completion or by timeout.
REQ-009 id_ok  output  1  last captured ID equals EXPECTED_ID.
REQ-010 ts_ok  output  1  last captured timestamp equals EXPECTED_TIMESTAMP.
REQ-011 timeout  output  1  last sequence aborted on timeout.
REQ-012 captured_id  output  32  word read from address 0.
REQ-013 captured_ts  output  32  word read from address 1.
REQ-014 avm_address  output  1  Avalon-MM word address.
REQ-015 avm_read  output  1  Avalon-MM read strobe.
REQ-016 avm_waitrequest  input  1  slave stall.
REQ-017 avm_readdata  input  32  slave read data.

Function
REQ-018 SHALL implement the FSM states IDLE, RD_ID, RD_TS, FINISH.
REQ-019 IDLE: when start=1, SHALL go to RD_ID, set busy=1, and clear id_ok, ts_ok and timeout.
REQ-020 RD_ID: SHALL drive avm_read=1 and avm_address=0, and hold both stable while avm_waitrequest=1.
REQ-021 A read SHALL complete in the cycle where avm_read=1 and avm_waitrequest=0 (zero-latency read); avm_readdata SHALL be sampled in that same cycle.
REQ-022 On RD_ID completion: SHALL load captured_id, set id_ok from the comparison, and go to RD_TS on the next cycle.
REQ-023 RD_TS: SHALL drive avm_read=1 and avm_address=1; on completion SHALL load captured_ts, set ts_ok, and go to FINISH.
REQ-024 FINISH: SHALL drive avm_read=0, pulse done for exactly one cycle, set busy=0, and return to IDLE.
REQ-025 SHALL keep a 16-bit stall counter that clears on entry to each read state and increments on each cycle with avm_waitrequest=1.
REQ-026 When the stall counter reaches TIMEOUT_CYCLES: SHALL set timeout=1, deassert avm_read, leave the untried captured_* register unchanged, and go to FINISH.
REQ-027 If TIMEOUT_CYCLES=0, SHALL disable timeout detection.
REQ-028 SHALL ignore start while busy=1.
REQ-029 A start in the FINISH cycle SHALL be ignored.
REQ-030 id_ok, ts_ok, timeout and captured_* SHALL hold their values until the next accepted start.
REQ-031 avm_read SHALL be 0 in IDLE and FINISH.
REQ-032 A minimum sequence with no stalls SHALL take 3 cycles from the start-sampling edge to the done pulse.

Reset
REQ-033 While reset=1: state=IDLE, busy=0, done=0, avm_read=0, avm_address=0, id_ok=0, ts_ok=0, timeout=0, captured_id=0, captured_ts=0, stall counter=0.
REQ-034 Reset asserted mid-read SHALL drop avm_read immediately (asynchronously) and abandon the sequence without a done pulse.

Configuration
REQ-035 Macro SYSID_READ_MASTER_RETRY_EN: when defined, SHALL restart a sequence that ends with id_ok=0, ts_ok=0 or timeout=1 from RD_ID exactly once.
REQ-036 With SYSID_READ_MASTER_RETRY_EN defined, SHALL keep busy=1 and withhold done until the retry finishes.
REQ-037 With SYSID_READ_MASTER_RETRY_EN defined, SHALL report the retry's results.
REQ-038 Without SYSID_READ_MASTER_RETRY_EN, SHALL end every sequence after one pass with no retry logic.

Verification
REQ-039 Slave returns 0 at address 0 and 1392009444 at address 1 with no stalls; pulse start -> done 3 cycles later, id_ok=1, ts_ok=1, timeout=0.
REQ-040 Slave holds waitrequest=1 for 5 cycles on address 1 -> avm_address=1 and avm_read=1 stable throughout, ts_ok=1, done 8 cycles after start.
REQ-041 Slave returns 32'h0000_0001 at address 0 -> id_ok=0, captured_id=1, ts_ok=1; with RETRY_EN, 2 full passes before done.
REQ-042 TIMEOUT_CYCLES=4 and waitrequest held at 1 -> timeout=1 after 4 stall cycles, done pulses, captured_ts=0.
REQ-043 Assert reset during RD_TS stall -> avm_read=0 in the same cycle, no done pulse, all outputs 0.
REQ-044 Pulse start again while busy -> ignored; exactly one done pulse per accepted start.

Source files
------------

// File: rtl/sysid_read_master.sv
// -----------------------------------------------------------------------------
// sysid_read_master
//
// Purpose:
//   Reads the two words of an Avalon-MM system ID peripheral and compares them
//   against expected values. Word address 0 holds the system ID and word
//   address 1 holds the build timestamp. One check sequence runs per accepted
//   start pulse. Results are held until the next accepted start.
//
// Optional feature:
//   SYSID_READ_MASTER_RETRY_EN - when defined, a sequence that ends with a
//   mismatch or a timeout is rerun once from the ID read. Busy stays high and
//   done is withheld until the retry finishes, so the outputs report the
//   retry's results. When undefined, every sequence makes exactly one pass.
//
// Parameters:
//   EXPECTED_ID        - system ID expected at word address 0
//   EXPECTED_TIMESTAMP - timestamp expected at word address 1
//   TIMEOUT_CYCLES     - maximum waitrequest stall cycles per read (0 = never)
//
// Ports:
//   clock            in   sole clock, rising edge
//   reset            in   asynchronous active-high reset
//   start            in   one-cycle pulse requesting a check sequence
//   busy             out  high while a sequence is in progress
//   done             out  one-cycle pulse at the end of a sequence
//   id_ok            out  last captured ID matched EXPECTED_ID
//   ts_ok            out  last captured timestamp matched EXPECTED_TIMESTAMP
//   timeout          out  last sequence was aborted by a stall timeout
//   captured_id      out  word read from address 0
//   captured_ts      out  word read from address 1
//   avm_address      out  Avalon-MM word address
//   avm_read         out  Avalon-MM read strobe
//   avm_waitrequest  in   Avalon-MM slave stall
//   avm_readdata     in   Avalon-MM read data
// -----------------------------------------------------------------------------
module sysid_read_master #(
   parameter logic [31:0] EXPECTED_ID        = 32'd0,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1392009444,
   parameter logic [15:0] TIMEOUT_CYCLES     = 16'd1023
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout,
   output logic [31:0] captured_id,
   output logic [31:0] captured_ts,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] RD_ID  = 2'd1;
   localparam logic [1:0] RD_TS  = 2'd2;
   localparam logic [1:0] FINISH = 2'd3;

   logic [1:0]  state_q,      state_d;
   logic [15:0] stall_q,      stall_d;
   logic        idOk_q,       idOk_d;
   logic        tsOk_q,       tsOk_d;
   logic        timeout_q,    timeout_d;
   logic [31:0] capturedId_q, capturedId_d;
   logic [31:0] capturedTs_q, capturedTs_d;
`ifdef SYSID_READ_MASTER_RETRY_EN
   logic        retried_q,    retried_d;
`endif

   logic [15:0] stallInc;
   logic        stallExpired;
   logic        retryNow;

   // Stall count after this cycle's stall. It saturates so that a disabled
   // timeout cannot wrap the counter back through small values.
   assign stallInc = (stall_q == 16'hFFFF) ? stall_q : (stall_q + 16'd1);

   // A stall cycle that brings the count up to the limit aborts the read, so
   // a read stalls for at most TIMEOUT_CYCLES cycles before the master gives up.
   assign stallExpired = (TIMEOUT_CYCLES != 16'd0) && avm_waitrequest &&
                         (stallInc == TIMEOUT_CYCLES);

   // Next-state logic. A read completes in any read-state cycle without
   // waitrequest; read data is sampled in that same cycle. The stall counter
   // is cleared whenever a read state is entered.
   always_comb begin
      state_d      = state_q;
      stall_d      = stall_q;
      idOk_d       = idOk_q;
      tsOk_d       = tsOk_q;
      timeout_d    = timeout_q;
      capturedId_d = capturedId_q;
      capturedTs_d = capturedTs_q;
      retryNow     = 1'b0;
`ifdef SYSID_READ_MASTER_RETRY_EN
      retried_d    = retried_q;
`endif

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = RD_ID;
               stall_d   = 16'd0;
               idOk_d    = 1'b0;
               tsOk_d    = 1'b0;
               timeout_d = 1'b0;
`ifdef SYSID_READ_MASTER_RETRY_EN
               retried_d = 1'b0;
`endif
            end
         end

         RD_ID: begin
            if (avm_waitrequest) begin
               stall_d = stallInc;
               if (stallExpired) begin
                  timeout_d = 1'b1;
                  state_d   = FINISH;
               end
            end else begin
               capturedId_d = avm_readdata;
               idOk_d       = (avm_readdata == EXPECTED_ID);
               stall_d      = 16'd0;
               state_d      = RD_TS;
            end
         end

         RD_TS: begin
            if (avm_waitrequest) begin
               stall_d = stallInc;
               if (stallExpired) begin
                  timeout_d = 1'b1;
                  state_d   = FINISH;
               end
            end else begin
               capturedTs_d = avm_readdata;
               tsOk_d       = (avm_readdata == EXPECTED_TIMESTAMP);
               state_d      = FINISH;
            end
         end

         FINISH: begin
            state_d = IDLE;
`ifdef SYSID_READ_MASTER_RETRY_EN
            // A failed first pass reruns the whole sequence once. The captured
            // words are kept so an untried read still shows its last value.
            if (!retried_q && (!idOk_q || !tsOk_q || timeout_q)) begin
               retryNow  = 1'b1;
               retried_d = 1'b1;
               state_d   = RD_ID;
               stall_d   = 16'd0;
               idOk_d    = 1'b0;
               tsOk_d    = 1'b0;
               timeout_d = 1'b0;
            end
`endif
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers. The asynchronous reset returns the FSM to IDLE at once,
   // which also drops avm_read without waiting for a clock edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         stall_q      <= 16'd0;
         idOk_q       <= 1'b0;
         tsOk_q       <= 1'b0;
         timeout_q    <= 1'b0;
         capturedId_q <= 32'd0;
         capturedTs_q <= 32'd0;
`ifdef SYSID_READ_MASTER_RETRY_EN
         retried_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         stall_q      <= stall_d;
         idOk_q       <= idOk_d;
         tsOk_q       <= tsOk_d;
         timeout_q    <= timeout_d;
         capturedId_q <= capturedId_d;
         capturedTs_q <= capturedTs_d;
`ifdef SYSID_READ_MASTER_RETRY_EN
         retried_q    <= retried_d;
`endif
      end
   end

   // Bus strobes are decoded from the state register only, so they are low in
   // IDLE and FINISH and stay stable for as long as the slave stalls.
   assign avm_read    = (state_q == RD_ID) || (state_q == RD_TS);
   assign avm_address = (state_q == RD_TS);

   // The FINISH cycle that launches a retry is still part of the sequence.
   assign busy = (state_q == RD_ID) || (state_q == RD_TS) || retryNow;
   assign done = (state_q == FINISH) && !retryNow;

   assign id_ok       = idOk_q;
   assign ts_ok       = tsOk_q;
   assign timeout     = timeout_q;
   assign captured_id = capturedId_q;
   assign captured_ts = capturedTs_q;

endmodule

// File: tb/tb_sysid_read_master.sv
// -----------------------------------------------------------------------------
// tb_sysid_read_master
//
// Self-checking bench for sysid_read_master. Instance A uses the default
// parameters and talks to a slave model with programmable memory words and
// per-address stall lengths. Instance B uses a stall limit of 4 and talks to
// a slave whose waitrequest can be forced high. Expected results are pushed
// to a scoreboard queue when a start is driven and popped when done appears.
// -----------------------------------------------------------------------------
module tb_sysid_read_master;

   localparam logic [31:0] TS_VAL = 32'd1392009444;

   typedef struct {
      logic        idOk;
      logic        tsOk;
      logic        tmo;
      logic [31:0] capId;
      logic [31:0] capTs;
      int          latency;
   } expT;

   expT sbq[$];
   int  vectors     = 0;
   int  miscompares = 0;

   logic        clock = 1'b0;
   logic        reset;
   logic        startA, startB;

   logic        busyA, doneA, idOkA, tsOkA, timeoutA, addrA, readA, waitA;
   logic [31:0] capIdA, capTsA, rdataA;
   logic        busyB, doneB, idOkB, tsOkB, timeoutB, addrB, readB, waitB;
   logic [31:0] capIdB, capTsB, rdataB;

   logic [31:0] memA0, memA1;
   int          stall0A, stall1A, slaveCntA;
   logic        holdWaitB;

   // Free-running clock, 10 time units per period.
   always #5 clock = ~clock;

   sysid_read_master dutA (
      .clock(clock), .reset(reset), .start(startA),
      .busy(busyA), .done(doneA), .id_ok(idOkA), .ts_ok(tsOkA),
      .timeout(timeoutA), .captured_id(capIdA), .captured_ts(capTsA),
      .avm_address(addrA), .avm_read(readA),
      .avm_waitrequest(waitA), .avm_readdata(rdataA)
   );

   sysid_read_master #(.TIMEOUT_CYCLES(16'd4)) dutB (
      .clock(clock), .reset(reset), .start(startB),
      .busy(busyB), .done(doneB), .id_ok(idOkB), .ts_ok(tsOkB),
      .timeout(timeoutB), .captured_id(capIdB), .captured_ts(capTsB),
      .avm_address(addrB), .avm_read(readB),
      .avm_waitrequest(waitB), .avm_readdata(rdataB)
   );

   // Slave A: zero-latency reads that stall a programmable number of cycles
   // per address before accepting.
   assign waitA  = readA && (slaveCntA < (addrA ? stall1A : stall0A));
   assign rdataA = addrA ? memA1 : memA0;

   always @(posedge clock) begin
      if (readA && waitA) slaveCntA <= slaveCntA + 1;
      else                slaveCntA <= 0;
   end

   // Slave B: the genuine ID/timestamp pair, with a forced-stall control.
   assign waitB  = readB && holdWaitB;
   assign rdataB = addrB ? TS_VAL : 32'd0;

   // Expected pass count for a sequence that fails its checks.
   function automatic int failScale();
`ifdef SYSID_READ_MASTER_RETRY_EN
      return 2;
`else
      return 1;
`endif
   endfunction

   // Pulses start for one cycle; called #1 after a rising edge.
   task automatic applyStimulus(input bit useB);
      if (useB) startB = 1'b1;
      else      startA = 1'b1;
      @(posedge clock);
      #1;
      startA = 1'b0;
      startB = 1'b0;
   endtask

   // Waits for done after the start-sampling edge. cycles is 1 in the first
   // cycle after that edge. Also records stall cycles on address 1 and any
   // cycle following such a stall in which the read strobe or address moved.
   task automatic waitDone(input bit useB, input int maxCycles,
                           output int cycles, output int stallHeld,
                           output int stallBroken);
      bit prevStall;
      bit seen;
      cycles      = 1;
      stallHeld   = 0;
      stallBroken = 0;
      prevStall   = 1'b0;
      seen        = 1'b0;
      while (cycles <= maxCycles) begin
         if (useB ? doneB : doneA) begin
            seen = 1'b1;
            break;
         end
         if (!useB) begin
            if (prevStall && !(readA && addrA)) stallBroken++;
            prevStall = readA && addrA && waitA;
            if (prevStall) stallHeld++;
         end
         @(posedge clock);
         #1;
         cycles++;
      end
      if (!seen) cycles = -1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      vectors++;
      if ({busyA, doneA, readA, addrA, idOkA, tsOkA, timeoutA} !== 7'd0) begin
         miscompares++;
         $display("[TB] FAIL reset.ctrlA got %b want 0000000",
                  {busyA, doneA, readA, addrA, idOkA, tsOkA, timeoutA});
      end
      vectors++;
      if ({capIdA, capTsA} !== 64'd0) begin
         miscompares++;
         $display("[TB] FAIL reset.capA got %h want 0", {capIdA, capTsA});
      end
      vectors++;
      if ({busyB, doneB, readB, timeoutB, capIdB, capTsB} !== 68'd0) begin
         miscompares++;
         $display("[TB] FAIL reset.B got %h want 0",
                  {busyB, doneB, readB, timeoutB, capIdB, capTsB});
      end
      reset = 1'b0;
      @(posedge clock);
      #1;
   endtask

   task automatic test_nominal();
      expT e;
      int cyc, sh, sb;
      bit busyEarly;
      memA0 = 32'd0; memA1 = TS_VAL; stall0A = 0; stall1A = 0;
      sbq.push_back('{1'b1, 1'b1, 1'b0, 32'd0, TS_VAL, 3});
      applyStimulus(1'b0);
      busyEarly = busyA;
      waitDone(1'b0, 40, cyc, sh, sb);
      e = sbq.pop_front();
      vectors++;
      if (busyEarly !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL nominal.busy got %b want 1", busyEarly);
      end
      vectors++;
      if (cyc !== e.latency) begin
         miscompares++;
         $display("[TB] FAIL nominal.latency got %0d want %0d", cyc, e.latency);
      end
      vectors++;
      if ({idOkA, tsOkA, timeoutA, readA, busyA} !== {e.idOk, e.tsOk, e.tmo, 2'b00}) begin
         miscompares++;
         $display("[TB] FAIL nominal.flags got %b want %b",
                  {idOkA, tsOkA, timeoutA, readA, busyA}, {e.idOk, e.tsOk, e.tmo, 2'b00});
      end
      vectors++;
      if ({capIdA, capTsA} !== {e.capId, e.capTs}) begin
         miscompares++;
         $display("[TB] FAIL nominal.cap got %h want %h", {capIdA, capTsA}, {e.capId, e.capTs});
      end
      @(posedge clock);
      #1;
      vectors++;
      if (doneA !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL nominal.donePulse got %b want 0", doneA);
      end
   endtask

   task automatic test_ts_stall();
      expT e;
      int cyc, sh, sb;
      memA0 = 32'd0; memA1 = TS_VAL; stall0A = 0; stall1A = 5;
      sbq.push_back('{1'b1, 1'b1, 1'b0, 32'd0, TS_VAL, 8});
      applyStimulus(1'b0);
      waitDone(1'b0, 40, cyc, sh, sb);
      e = sbq.pop_front();
      vectors++;
      if (cyc !== e.latency) begin
         miscompares++;
         $display("[TB] FAIL tsStall.latency got %0d want %0d", cyc, e.latency);
      end
      vectors++;
      if (sh !== 5 || sb !== 0) begin
         miscompares++;
         $display("[TB] FAIL tsStall.hold got %0d/%0d want 5/0", sh, sb);
      end
      vectors++;
      if ({idOkA, tsOkA, timeoutA} !== {e.idOk, e.tsOk, e.tmo}) begin
         miscompares++;
         $display("[TB] FAIL tsStall.flags got %b want %b",
                  {idOkA, tsOkA, timeoutA}, {e.idOk, e.tsOk, e.tmo});
      end
      stall1A = 0;
      @(posedge clock);
      #1;
   endtask

   task automatic test_bad_id();
      expT e;
      int cyc, sh, sb;
      memA0 = 32'h0000_0001; memA1 = TS_VAL; stall0A = 0; stall1A = 0;
      sbq.push_back('{1'b0, 1'b1, 1'b0, 32'h0000_0001, TS_VAL, 3 * failScale()});
      applyStimulus(1'b0);
      waitDone(1'b0, 40, cyc, sh, sb);
      e = sbq.pop_front();
      vectors++;
      if (cyc !== e.latency) begin
         miscompares++;
         $display("[TB] FAIL badId.latency got %0d want %0d", cyc, e.latency);
      end
      vectors++;
      if ({idOkA, tsOkA, timeoutA, capIdA} !== {e.idOk, e.tsOk, e.tmo, e.capId}) begin
         miscompares++;
         $display("[TB] FAIL badId.result got %h want %h",
                  {idOkA, tsOkA, timeoutA, capIdA}, {e.idOk, e.tsOk, e.tmo, e.capId});
      end
      memA0 = 32'd0;
      @(posedge clock);
      #1;
   endtask

   task automatic test_timeout();
      expT e;
      int cyc, sh, sb;
      holdWaitB = 1'b1;
      sbq.push_back('{1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 5 * failScale()});
      applyStimulus(1'b1);
      waitDone(1'b1, 40, cyc, sh, sb);
      e = sbq.pop_front();
      vectors++;
      if (cyc !== e.latency) begin
         miscompares++;
         $display("[TB] FAIL timeout.latency got %0d want %0d", cyc, e.latency);
      end
      vectors++;
      if ({idOkB, tsOkB, timeoutB, readB} !== {e.idOk, e.tsOk, e.tmo, 1'b0}) begin
         miscompares++;
         $display("[TB] FAIL timeout.flags got %b want %b",
                  {idOkB, tsOkB, timeoutB, readB}, {e.idOk, e.tsOk, e.tmo, 1'b0});
      end
      vectors++;
      if ({capIdB, capTsB} !== {e.capId, e.capTs}) begin
         miscompares++;
         $display("[TB] FAIL timeout.cap got %h want %h", {capIdB, capTsB}, {e.capId, e.capTs});
      end
      holdWaitB = 1'b0;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset_midread();
      int guard;
      int dones;
      memA0 = 32'd0; memA1 = TS_VAL; stall0A = 0; stall1A = 1000;
      applyStimulus(1'b0);
      guard = 0;
      while (!(readA && addrA) && guard < 10) begin
         @(posedge clock);
         #1;
         guard++;
      end
      vectors++;
      if (!(readA && addrA)) begin
         miscompares++;
         $display("[TB] FAIL midRead.reachTs got %b want 1", readA && addrA);
      end
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      #1;
      vectors++;
      if ({readA, busyA, doneA, addrA, idOkA, tsOkA, timeoutA, capIdA, capTsA} !== 71'd0) begin
         miscompares++;
         $display("[TB] FAIL midRead.asyncClear got %h want 0",
                  {readA, busyA, doneA, addrA, idOkA, tsOkA, timeoutA, capIdA, capTsA});
      end
      @(posedge clock);
      #1;
      reset = 1'b0;
      stall1A = 0;
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         if (doneA || busyA) dones++;
         @(posedge clock);
         #1;
      end
      vectors++;
      if (dones !== 0) begin
         miscompares++;
         $display("[TB] FAIL midRead.noDone got %0d want 0", dones);
      end
   endtask

   task automatic test_start_while_busy();
      expT e;
      int dones, firstDone;
      memA0 = 32'd0; memA1 = TS_VAL; stall0A = 0; stall1A = 5;
      sbq.push_back('{1'b1, 1'b1, 1'b0, 32'd0, TS_VAL, 8});
      startA = 1'b1;
      @(posedge clock);
      #1;
      dones = 0;
      firstDone = -1;
      // start stays high through every busy cycle and the FINISH cycle.
      for (int cyc = 1; cyc <= 20; cyc++) begin
         if (cyc == 9) startA = 1'b0;
         if (doneA) begin
            dones++;
            if (firstDone < 0) firstDone = cyc;
         end
         @(posedge clock);
         #1;
      end
      e = sbq.pop_front();
      vectors++;
      if (dones !== 1 || firstDone !== e.latency) begin
         miscompares++;
         $display("[TB] FAIL busyStart.dones got %0d@%0d want 1@%0d", dones, firstDone, e.latency);
      end
      vectors++;
      if ({busyA, idOkA, tsOkA, timeoutA} !== {1'b0, e.idOk, e.tsOk, e.tmo}) begin
         miscompares++;
         $display("[TB] FAIL busyStart.flags got %b want %b",
                  {busyA, idOkA, tsOkA, timeoutA}, {1'b0, e.idOk, e.tsOk, e.tmo});
      end
      stall1A = 0;
   endtask

   task automatic test_back_to_back();
      expT e;
      int cyc, sh, sb;
      bit pass;
      for (int n = 0; n < 5; n++) begin
         memA0   = ($urandom_range(0, 1) == 1) ? 32'd0 : $urandom;
         memA1   = ($urandom_range(0, 1) == 1) ? TS_VAL : $urandom;
         stall0A = $urandom_range(0, 3);
         stall1A = $urandom_range(0, 3);
         pass    = (memA0 == 32'd0) && (memA1 == TS_VAL);
         sbq.push_back('{memA0 == 32'd0, memA1 == TS_VAL, 1'b0, memA0, memA1,
                         (3 + stall0A + stall1A) * (pass ? 1 : failScale())});
         applyStimulus(1'b0);
         waitDone(1'b0, 60, cyc, sh, sb);
         e = sbq.pop_front();
         vectors++;
         if (cyc !== e.latency) begin
            miscompares++;
            $display("[TB] FAIL b2b%0d.latency got %0d want %0d", n, cyc, e.latency);
         end
         vectors++;
         if ({idOkA, tsOkA, timeoutA, capIdA, capTsA} !== {e.idOk, e.tsOk, e.tmo, e.capId, e.capTs}) begin
            miscompares++;
            $display("[TB] FAIL b2b%0d.result got %h want %h", n,
                     {idOkA, tsOkA, timeoutA, capIdA, capTsA}, {e.idOk, e.tsOk, e.tmo, e.capId, e.capTs});
         end
         @(posedge clock);
         #1;
      end
      stall0A = 0;
      stall1A = 0;
   endtask

   initial begin
      reset     = 1'b1;
      startA    = 1'b0;
      startB    = 1'b0;
      holdWaitB = 1'b0;
      memA0     = 32'd0;
      memA1     = TS_VAL;
      stall0A   = 0;
      stall1A   = 0;
      slaveCntA = 0;
      $display("[TB] sysid_read_master bench starting");
      test_reset();
      test_nominal();
      test_ts_stall();
      test_bad_id();
      test_timeout();
      test_reset_midread();
      test_start_while_busy();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
